mmio_uart_tx: RTL and testbench
===============================

# mmio_uart_tx

Memory-mapped UART transmitter on the CPU's data-memory store path, downstream of the load/store unit and in parallel with the data RAM. A store to `TX_ADDR` pushes one byte into a TX FIFO. A frame serializer drains the FIFO onto `uart_tx`. A status word at `STATUS_ADDR` lets firmware poll for space and idle, so trace and benchmark output leaves the core without a host-side RAM dump.

## Interface
- `CLK_DIV`, default 1085: clock cycles per UART bit, ≥2.
- `FIFO_DEPTH`, default 16: FIFO entries, power of two, ≥2.
- `TX_ADDR`, default 32'h0000_F6FC: byte-push address.
- `STATUS_ADDR`, default 32'h0000_F6F8: status/clear address.
- `clk`, input, 1: clock.
- `rst`, input, 1: synchronous, active-high reset.
- `we`, input, 1: store strobe, one cycle per store.
- `addr`, input, 32: store/load address, full compare.
- `wdata`, input, 32: store data; only bits [7:0] are used.
- `rdata`, output, 32: status word, combinational from `addr`.
- `uart_tx`, output, 1: serial line, registered, idles high.
- `busy`, output, 1: FIFO non-empty or frame in progress.

## Operation
- Push: `we && addr==TX_ADDR` and FIFO not full writes `wdata[7:0]` at the write pointer.
- Push when full: the byte is dropped and the sticky `overflow` flag is set.
- Clear: `we && addr==STATUS_ADDR` clears `overflow`. If a drop occurs in the same cycle, set wins.
- Full/empty: evaluated from the registered count at the start of the cycle. There is no bypass.
- Push and pop in the same cycle: both take effect and the count is unchanged. A push to an empty FIFO is not popped in that cycle.
- Pointers: `log2(FIFO_DEPTH)` bits, wrap modulo depth. Count is `log2(FIFO_DEPTH)+1` bits.
- `rdata` when `addr==STATUS_ADDR`: {27'b0, parity_en, overflow, busy, full, empty}. `parity_en` is 1 only when the configuration macro is defined. For any other `addr`, `rdata` is 0.
- `busy` = (state != IDLE) || !empty.
- FSM states: IDLE, START, DATA, PARITY (present only when configured), STOP.
  - IDLE: if FIFO non-empty, pop into shift register, clear bit counter, go to START. Otherwise stay.
  - START: `uart_tx`=0.
  - DATA: 8 bits, LSB first.
  - PARITY: even parity of the byte.
  - STOP: `uart_tx`=1.
  - After STOP: return to IDLE.
- Each non-IDLE state lasts exactly `CLK_DIV` cycles. A baud counter runs 0..`CLK_DIV`-1 and is zeroed on every state or bit change.
- Reset values: `uart_tx`=1, state IDLE, FIFO empty, pointers 0, `overflow`=0, baud and bit counters 0, `busy`=0.
- Reset mid-frame: aborts the frame and flushes the FIFO. `uart_tx`=1 after the reset edge.

## Timing
- A store presented in cycle N is stored at edge N.
- Edge N+1 pops the byte and drives `uart_tx` low, when idle and the FIFO was empty.
- Frame length is 10×`CLK_DIV` cycles, or 11×`CLK_DIV` with parity.
- Back-to-back frames are separated by exactly one IDLE cycle (line high).
- Minimum push-to-push spacing is 1 cycle. The CPU's multi-cycle store (one `we` per instruction) never exceeds this.
- Status is combinational and reflects registered state.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
  - Defined: PARITY state between DATA and STOP carries the even parity bit. Frame is 11 bits. `rdata[4]`=1.
  - Undefined: no PARITY state. Frame is 10 bits (8N1). `rdata[4]`=0.

## Test plan
- Reset: after `rst` high for one edge, `uart_tx`=1, `busy`=0, status read returns 32'h1 (32'h11 with parity).
- Single byte: `CLK_DIV`=4, push 0x55 while idle. Required response:
  - `uart_tx` low from edge N+1 for 4 cycles.
  - Then 1,0,1,0,1,0,1,0 at 4 cycles each.
  - Then high for 4 cycles.
  - `busy` falls after STOP.
- Back-to-back: push 0x01, 0x02, 0x03 on consecutive cycles. Required response: three frames, each separated by exactly 1 high idle cycle, bytes in push order.
- Overflow: `FIFO_DEPTH`=4, idle, push A..F on six consecutive cycles. Required response:
  - A is popped at edge 1.
  - F is rejected (FIFO full at edge 5) and `overflow`=1.
  - A–E are transmitted.
  - A write to `STATUS_ADDR` clears `overflow`.
- Reset mid-frame: assert `rst` during DATA bit 3. Required response: `uart_tx`=1 next edge, FIFO empty, no frame resumes.
- Parity (macro defined): push 0x07. Required response: parity bit 1; push 0x03 gives parity bit 0. Frame is 11×`CLK_DIV` cycles.

Source files
------------

// File: rtl/mmio_uart_tx_if.sv
// rtl/mmio_uart_tx_if.sv - store/load bus bundle between the load/store unit and the UART transmitter
interface mmio_uart_tx_if;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output we, output addr, output wdata, input rdata);
   modport slave  (input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped UART TX with byte FIFO; optional parity via UART_TX_PARITY_EN
module mmio_uart_tx #(
   parameter int unsigned CLK_DIV     = 1085,
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter logic [31:0] TX_ADDR     = 32'h0000_F6FC,
   parameter logic [31:0] STATUS_ADDR = 32'h0000_F6F8
) (
   input  logic          clk,
   input  logic          rst,
   mmio_uart_tx_if.slave bus,
   output logic          uart_tx,
   output logic          busy
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

`ifdef UART_TX_PARITY_EN
   localparam logic PAR_EN = 1'b1;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   localparam logic PAR_EN = 1'b0;
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          overflow;
   logic          full, empty, push_req, push, drop, clr, pop;

   state_t        state, state_d;
   logic [BW-1:0] baud_cnt, baud_d;
   logic [2:0]    bit_cnt, bit_d;
   logic [7:0]    shreg, shreg_d;
   logic          par, par_d, tx_d;

   // wdata[31:8] is intentionally ignored; only the low byte is transmitted
   logic          unused_wdata;
   assign unused_wdata = ^bus.wdata[31:8];

   assign full     = (count == DEPTH_C);
   assign empty    = (count == '0);
   assign push_req = bus.we && (bus.addr == TX_ADDR);
   assign push     = push_req && !full;
   assign drop     = push_req && full;
   assign clr      = bus.we && (bus.addr == STATUS_ADDR);
   assign busy     = (state != IDLE) || !empty;

   // FIFO storage write; contents need no reset since count gates every read
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.wdata[7:0];
   end

   // FIFO pointers, occupancy and the sticky overflow flag (set beats clear)
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (drop)     overflow <= 1'b1;
         else if (clr) overflow <= 1'b0;
      end
   end

   // serializer state register; line output is registered and idles high
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         par      <= 1'b0;
         uart_tx  <= 1'b1;
      end else begin
         state    <= state_d;
         baud_cnt <= baud_d;
         bit_cnt  <= bit_d;
         shreg    <= shreg_d;
         par      <= par_d;
         uart_tx  <= tx_d;
      end
   end

   // next-state, baud/bit counting, pop decision and the next line level
   always_comb begin
      state_d = state;
      baud_d  = baud_cnt + BW'(1);
      bit_d   = bit_cnt;
      shreg_d = shreg;
      par_d   = par;
      pop     = 1'b0;
      case (state)
         IDLE: begin
            baud_d = '0;
            if (!empty) begin
               pop     = 1'b1;
               shreg_d = mem[rd_ptr];
               par_d   = ^mem[rd_ptr];
               bit_d   = '0;
               state_d = START;
            end
         end
         START: begin
            if (baud_cnt == BAUD_LAST) begin
               baud_d  = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (baud_cnt == BAUD_LAST) begin
               baud_d  = '0;
               shreg_d = shreg >> 1;
               if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_d = bit_cnt + 3'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (baud_cnt == BAUD_LAST) begin
               baud_d  = '0;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (baud_cnt == BAUD_LAST) begin
               baud_d  = '0;
               state_d = IDLE;
            end
         end
         default: begin
            baud_d  = '0;
            state_d = IDLE;
         end
      endcase

      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_d = par_d;
`endif
         default: tx_d = 1'b1;
      endcase
   end

   // status word decode, combinational from addr over registered state
   always_comb begin
      bus.rdata = '0;
      if (bus.addr == STATUS_ADDR)
         bus.rdata = {27'b0, PAR_EN, overflow, busy, full, empty};
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - directed self-checking bench for mmio_uart_tx
module tb_mmio_uart_tx;
   localparam int          CD    = 4;
   localparam int          DEPTH = 4;
   localparam logic [31:0] TXA   = 32'h0000_F6FC;
   localparam logic [31:0] STA   = 32'h0000_F6F8;
`ifdef UART_TX_PARITY_EN
   localparam int          FB    = 11;
   localparam bit          PB    = 1'b1;
   localparam logic [31:0] PARB  = 32'h10;
`else
   localparam int          FB    = 10;
   localparam bit          PB    = 1'b0;
   localparam logic [31:0] PARB  = 32'h00;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic uart_tx, busy;
   int   n_cmp  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   mmio_uart_tx_if bus ();

   mmio_uart_tx #(
      .CLK_DIV     (CD),
      .FIFO_DEPTH  (DEPTH),
      .TX_ADDR     (TXA),
      .STATUS_ADDR (STA)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .uart_tx (uart_tx),
      .busy    (busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      bus.we    = 1'b0;
      bus.addr  = 32'h0;
      bus.wdata = 32'h0;
   endtask

   task automatic push(input logic [7:0] b);
      bus.we    = 1'b1;
      bus.addr  = TXA;
      bus.wdata = {24'hABCDEF, b};
      step();
      bus_idle();
   endtask

   // expected line bits, bit 0 = start; stop sits after data (and parity)
   function automatic logic [10:0] frame_of(input logic [7:0] b, input logic p);
      return PB ? {1'b1, p, b, 1'b0} : {1'b0, 1'b1, b, 1'b0};
   endfunction

   // monitor: records the level of each bit period, counts periods that wobble
   task automatic capture_frame(output logic [10:0] seen, output int bad);
      seen = '0;
      bad  = 0;
      for (int i = 0; i < FB; i++) begin
         seen[i] = uart_tx;
         for (int c = 0; c < CD; c++) begin
            if (uart_tx !== seen[i]) bad++;
            step();
         end
      end
   endtask

   task automatic wait_start(output bit ok);
      int k;
      k = 0;
      while (uart_tx !== 1'b0 && k < 200) begin
         step();
         k++;
      end
      ok = (uart_tx === 1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus_idle();
      step();
      step();
      n_cmp++;
      if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
      n_cmp++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      bus.addr = STA; #1;
      n_cmp++;
      if (bus.rdata !== (32'h1 | PARB)) begin n_fail++; $display("FAIL reset_status: got %h want %h", bus.rdata, 32'h1 | PARB); end
      bus.addr = TXA; #1;
      n_cmp++;
      if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL rdata_txaddr: got %h want 0", bus.rdata); end
      bus.addr = 32'h0000_F6F4; #1;
      n_cmp++;
      if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL rdata_other: got %h want 0", bus.rdata); end
      bus_idle();
      rst = 1'b0;
      step();
   endtask

   task automatic test_single_byte();
      logic [10:0] seen;
      int          bad;
      push(8'h55);
      n_cmp++;
      if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL single_pre_tx: got %b want 1", uart_tx); end
      bus.addr = STA; #1;
      n_cmp++;
      if (bus.rdata !== (32'h4 | PARB)) begin n_fail++; $display("FAIL single_status: got %h want %h", bus.rdata, 32'h4 | PARB); end
      bus_idle();
      step();
      capture_frame(seen, bad);
      n_cmp++;
      if (seen !== frame_of(8'h55, 1'b0) || bad != 0)
         begin n_fail++; $display("FAIL single_frame: got %b (%0d wobbles) want %b", seen, bad, frame_of(8'h55, 1'b0)); end
      n_cmp++;
      if (uart_tx !== 1'b1 || busy !== 1'b0)
         begin n_fail++; $display("FAIL single_after: tx=%b busy=%b want tx=1 busy=0", uart_tx, busy); end
      step();
   endtask

   task automatic test_back_to_back();
      logic [7:0]  bytes [3] = '{8'h01, 8'h02, 8'h03};
      logic        pars  [3] = '{1'b1, 1'b1, 1'b0};
      logic [10:0] seen;
      int          bad;
      bit          ok;
      fork
         begin
            push(8'h01);
            push(8'h02);
            push(8'h03);
         end
         begin
            wait_start(ok);
            n_cmp++;
            if (!ok) begin n_fail++; $display("FAIL b2b_start: got tx=%b want start bit", uart_tx); end
            for (int f = 0; f < 3; f++) begin
               capture_frame(seen, bad);
               n_cmp++;
               if (seen !== frame_of(bytes[f], pars[f]) || bad != 0)
                  begin n_fail++; $display("FAIL b2b_frame%0d: got %b (%0d wobbles) want %b", f, seen, bad, frame_of(bytes[f], pars[f])); end
               n_cmp++;
               if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL b2b_idle%0d: got %b want 1", f, uart_tx); end
               step();
            end
            n_cmp++;
            if (busy !== 1'b0 || uart_tx !== 1'b1)
               begin n_fail++; $display("FAIL b2b_end: busy=%b tx=%b want busy=0 tx=1", busy, uart_tx); end
         end
      join
   endtask

   task automatic test_overflow();
      logic [7:0]  bytes [5] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
      logic        pars  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [10:0] seen;
      int          bad;
      bit          ok;
      fork
         begin
            for (int i = 0; i < 5; i++) push(bytes[i]);
            push(8'hF6);
            bus.addr = STA; #1;
            n_cmp++;
            if (bus.rdata !== (32'hE | PARB)) begin n_fail++; $display("FAIL ovf_set: got %h want %h", bus.rdata, 32'hE | PARB); end
            bus.we = 1'b1; bus.addr = STA; bus.wdata = 32'h0;
            step();
            bus_idle();
            bus.addr = STA; #1;
            n_cmp++;
            if (bus.rdata !== (32'h6 | PARB)) begin n_fail++; $display("FAIL ovf_clear: got %h want %h", bus.rdata, 32'h6 | PARB); end
            bus_idle();
         end
         begin
            wait_start(ok);
            n_cmp++;
            if (!ok) begin n_fail++; $display("FAIL ovf_start: got tx=%b want start bit", uart_tx); end
            for (int f = 0; f < 5; f++) begin
               capture_frame(seen, bad);
               n_cmp++;
               if (seen !== frame_of(bytes[f], pars[f]) || bad != 0)
                  begin n_fail++; $display("FAIL ovf_frame%0d: got %b (%0d wobbles) want %b", f, seen, bad, frame_of(bytes[f], pars[f])); end
               n_cmp++;
               if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL ovf_idle%0d: got %b want 1", f, uart_tx); end
               step();
            end
            n_cmp++;
            if (busy !== 1'b0) begin n_fail++; $display("FAIL ovf_sixth: busy=%b want 0 (dropped byte must not send)", busy); end
         end
      join
      bus.addr = STA; #1;
      n_cmp++;
      if (bus.rdata !== (32'h1 | PARB)) begin n_fail++; $display("FAIL ovf_final: got %h want %h", bus.rdata, 32'h1 | PARB); end
      bus_idle();
      step();
   endtask

   task automatic test_reset_mid_frame();
      bit ok;
      int bad;
      push(8'h34);
      push(8'h5A);
      wait_start(ok);
      n_cmp++;
      if (!ok) begin n_fail++; $display("FAIL rmf_start: got tx=%b want start bit", uart_tx); end
      for (int i = 0; i < CD + 3 * CD + 1; i++) step();
      n_cmp++;
      if (uart_tx !== 1'b0) begin n_fail++; $display("FAIL rmf_bit3: got %b want 0", uart_tx); end
      rst = 1'b1;
      step();
      n_cmp++;
      if (uart_tx !== 1'b1 || busy !== 1'b0)
         begin n_fail++; $display("FAIL rmf_after: tx=%b busy=%b want tx=1 busy=0", uart_tx, busy); end
      bus.addr = STA; #1;
      n_cmp++;
      if (bus.rdata !== (32'h1 | PARB)) begin n_fail++; $display("FAIL rmf_status: got %h want %h", bus.rdata, 32'h1 | PARB); end
      bus_idle();
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 2 * FB * CD; i++) begin
         if (uart_tx !== 1'b1 || busy !== 1'b0) bad++;
         step();
      end
      n_cmp++;
      if (bad != 0) begin n_fail++; $display("FAIL rmf_quiet: %0d active cycles after reset, want 0", bad); end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      logic [10:0] seen;
      int          bad;
      push(8'h07);
      step();
      capture_frame(seen, bad);
      n_cmp++;
      if (seen[9] !== 1'b1) begin n_fail++; $display("FAIL par_07: parity=%b want 1", seen[9]); end
      n_cmp++;
      if (seen !== 11'b1_1_00000111_0 || bad != 0 || uart_tx !== 1'b1)
         begin n_fail++; $display("FAIL par_07_frame: got %b (%0d wobbles) want %b", seen, bad, 11'b1_1_00000111_0); end
      step();
      push(8'h03);
      step();
      capture_frame(seen, bad);
      n_cmp++;
      if (seen[9] !== 1'b0) begin n_fail++; $display("FAIL par_03: parity=%b want 0", seen[9]); end
      n_cmp++;
      if (seen !== 11'b1_0_00000011_0 || bad != 0 || busy !== 1'b0)
         begin n_fail++; $display("FAIL par_03_frame: got %b (%0d wobbles) want %b", seen, bad, 11'b1_0_00000011_0); end
      step();
   endtask
`endif

   initial begin
      bus_idle();
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_overflow();
      test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
